mem_bus_master: RTL and testbench

- Cache-side initiator for the 18-bit address / 16-bit data / 2-bit command memory bus.
- The memory model is the responder on this bus.
- Takes one line-level read or write request from the cache core and sequences the bus ownership handshake.
- Transfers a line as WORDS_PER_LINE consecutive bus words, then returns the line or a completion pulse to the cache.

---
 rtl/mem_bus_master.sv | 154 +++++++++++++++
 tb/tb_mem_bus_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Cache-side bus initiator: turns one line read/write request into a
// CMD / data-beat / turnaround / response sequence on the shared A2/D2/C2
// bus, with a bounded wait for the memory RESPONSE.
module mem_bus_master #(
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int TIMEOUT        = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] req_wdata,
  output logic                             req_ready,
  output logic                             rsp_done,
  output logic                             rsp_error,
  output logic [DATA_W*WORDS_PER_LINE-1:0] rsp_rdata,
  output logic [ADDR_W-1:0]                A2,
  inout  wire  [DATA_W-1:0]                D2,
  inout  wire  [1:0]                       C2
);

  localparam int WPL = WORDS_PER_LINE;
  localparam int BW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int CW  = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [BW-1:0] LAST = BW'(WPL - 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_RESP = 2'd1;
  localparam logic [1:0] CMD_RD   = 2'd2;
  localparam logic [1:0] CMD_WR   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WDATA, S_TURN, S_WAIT_RD, S_WAIT_WR, S_RECLAIM
  } state_t;

  state_t state, nstate;

  logic                       write_q;
  logic                       err_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [WPL-1:0][DATA_W-1:0] wbuf;
  logic [WPL-1:0][DATA_W-1:0] rbuf;
  logic [WPL-1:0][DATA_W-1:0] line_n;
  logic [BW-1:0]              bcnt;
  logic [CW-1:0]              wcnt;

  logic resp, cap, cap_last, go_err;
  logic own, d2_en;
  logic [1:0] c2_o;

  // C2 is only meaningful while released; our own drive is never RESPONSE
  assign resp = (C2 == CMD_RESP);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  // next-state: response beats, short-burst abort and wait timeout
  always_comb begin
    nstate   = state;
    cap      = 1'b0;
    cap_last = 1'b0;
    go_err   = 1'b0;
    line_n   = rbuf;
    line_n[LAST] = D2;
    unique case (state)
      S_IDLE:  if (req_valid) nstate = S_CMD;
      S_CMD:   nstate = (write_q && WPL > 1) ? S_WDATA : S_TURN;
      S_WDATA: if (bcnt == LAST) nstate = S_TURN;
      S_TURN:  nstate = write_q ? S_WAIT_WR : S_WAIT_RD;
      S_WAIT_RD: begin
        if (resp) begin
          cap = 1'b1;
          if (bcnt == LAST) begin
            cap_last = 1'b1;
            nstate   = S_RECLAIM;
          end
        end else if (bcnt != '0 || wcnt == TLIM) begin
          // burst broke off, or memory never answered
          go_err = 1'b1;
          nstate = S_RECLAIM;
        end
      end
      S_WAIT_WR: begin
        if (resp) nstate = S_RECLAIM;
        else if (wcnt == TLIM) begin
          go_err = 1'b1;
          nstate = S_RECLAIM;
        end
      end
      S_RECLAIM: nstate = S_IDLE;
      default:   nstate = S_IDLE;
    endcase
  end

  // request latch, beat/timeout counters, read assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      bcnt      <= '0;
      wcnt      <= '0;
      rsp_rdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          write_q <= req_write;
          addr_q  <= req_addr;
          wbuf    <= req_wdata;
          bcnt    <= '0;
          err_q   <= 1'b0;
        end
        S_CMD, S_WDATA: bcnt <= bcnt + 1'b1;
        S_TURN: begin
          bcnt <= '0;
          wcnt <= '0;
        end
        S_WAIT_RD, S_WAIT_WR: begin
          if (cap) begin
            rbuf[bcnt] <= D2;
            bcnt       <= bcnt + 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
          if (cap_last) rsp_rdata <= line_n;
          if (go_err)   err_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // bus ownership: gated by rst_n so reset releases the bus at once
  assign own   = rst_n && (state == S_IDLE || state == S_CMD || state == S_WDATA);
  assign d2_en = rst_n && write_q && (state == S_CMD || state == S_WDATA);
  assign c2_o  = (state == S_IDLE) ? CMD_NOP : (write_q ? CMD_WR : CMD_RD);
  assign C2    = own   ? c2_o       : 'z;
  assign D2    = d2_en ? wbuf[bcnt] : 'z;
  assign A2    = (state == S_IDLE) ? '0 : addr_q;

  assign req_ready = rst_n && (state == S_IDLE);
  assign rsp_done  = (state == S_RECLAIM);
  assign rsp_error = (state == S_RECLAIM) && err_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a transaction-level expected-bus timeline is
// queued per request and compared every cycle; bus pull-ups make a released
// C2/D2 read as all ones.
module tb_mem_bus_master;

  localparam int TO  = 120;
  localparam int WPL = 8;
  localparam logic [1:0]  REL  = 2'b11;
  localparam logic [15:0] DREL = 16'hFFFF;

  typedef struct {
    logic [1:0]   c2;
    logic [17:0]  a2;
    logic [15:0]  d2;
    bit           rdy, done, err, upd;
    logic [127:0] rd;
  } rec_t;

  logic         clk, rst_n;
  logic         req_valid, req_write;
  logic [17:0]  req_addr;
  logic [127:0] req_wdata;
  logic         req_ready, rsp_done, rsp_error;
  logic [127:0] rsp_rdata;
  logic [17:0]  a2;
  wire  [15:0]  d2;
  wire  [1:0]   c2;

  logic        tb_drv;
  logic [1:0]  tb_c2;
  logic [15:0] tb_d2;

  assign c2 = tb_drv ? tb_c2 : 2'bz;
  assign d2 = tb_drv ? tb_d2 : 16'bz;

  for (genvar i = 0; i < 2; i++) begin : g_pc
    pullup (c2[i]);
  end
  for (genvar i = 0; i < 16; i++) begin : g_pd
    pullup (d2[i]);
  end

  mem_bus_master #(.ADDR_W(18), .DATA_W(16), .WORDS_PER_LINE(WPL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_done(rsp_done), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .A2(a2), .D2(d2), .C2(c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit chk_en = 0;
  rec_t exp_q[$];
  logic [127:0] exp_rdata = '0;

  // monitor-derived facts used by the hand-computed pins
  int cmd_cyc = 0, done_cyc = -1000, gap = 0, ndone = 0, nrd = 0, nwr = 0;
  bit last_err = 0, prev_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic void push(logic [1:0] c, logic [17:0] a, logic [15:0] d,
                               bit rdy, bit done, bit err, bit upd, logic [127:0] rd);
    rec_t r;
    r.c2 = c; r.a2 = a; r.d2 = d; r.rdy = rdy; r.done = done; r.err = err;
    r.upd = upd; r.rd = rd;
    exp_q.push_back(r);
  endfunction

  function automatic logic [127:0] mkline(logic [15:0] base, logic [15:0] step);
    logic [127:0] l;
    for (int k = 0; k < WPL; k++) l[16*k +: 16] = base + step * 16'(k);
    return l;
  endfunction

  // per-cycle compare against the queued timeline (idle bus when empty)
  initial begin
    rec_t r;
    forever begin
      @(negedge clk); #1;
      if (chk_en) begin
        if (exp_q.size() > 0) r = exp_q.pop_front();
        else begin
          r.c2 = 2'b00; r.a2 = '0; r.d2 = DREL; r.rdy = 1; r.done = 0;
          r.err = 0; r.upd = 0; r.rd = '0;
        end
        if (r.upd) exp_rdata = r.rd;
        chk("C2", c2, r.c2);
        chk("A2", a2, r.a2);
        chk("D2", d2, r.d2);
        chk("req_ready", req_ready, r.rdy);
        chk("rsp_done", rsp_done, r.done);
        chk("rsp_error", rsp_error, r.err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
      end
    end
  end

  // event monitor: command start, completion, command-cycle counts
  initial begin
    forever begin
      @(negedge clk); #1;
      if (prev_rdy && !req_ready && rst_n) begin
        cmd_cyc = cyc;
        gap = cyc - done_cyc - 1;
      end
      if (rsp_done) begin
        done_cyc = cyc; ndone++; last_err = rsp_error;
      end
      if (c2 === 2'b10) nrd++;
      if (c2 === 2'b11 && d2[15:12] === 4'hA) nwr++;
      prev_rdy = req_ready;
    end
  end

  task automatic clr_mon();
    ndone = 0; nrd = 0; nwr = 0; last_err = 0;
  endtask

  // read line; nw = words memory returns (0 = never answers)
  task automatic do_read(input logic [17:0] addr, input int lat, input int nw,
                         input logic [127:0] line, input bit hold);
    int waits, nrec;
    @(negedge clk); #2;
    req_valid = 1; req_write = 0; req_addr = addr;
    req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    waits = (nw == 0) ? TO : lat;
    push(2'b10, addr, DREL, 0, 0, 0, 0, '0);
    push(REL, addr, DREL, 0, 0, 0, 0, '0);
    repeat (waits) push(REL, addr, DREL, 0, 0, 0, 0, '0);
    for (int k = 0; k < nw; k++) push(2'b01, addr, line[16*k +: 16], 0, 0, 0, 0, '0);
    if (nw > 0 && nw < WPL) push(REL, addr, DREL, 0, 0, 0, 0, '0);
    push(REL, addr, DREL, 0, 1, nw < WPL, nw == WPL, line);
    nrec = 2 + waits + nw + ((nw > 0 && nw < WPL) ? 1 : 0) + 1;
    @(posedge clk); #1;
    if (!hold) req_valid = 0;
    req_addr = ~addr; req_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int j = 1; j < nrec; j++) begin
      @(posedge clk); #1;
      if (nw > 0 && j >= 2 + lat && j < 2 + lat + nw) begin
        tb_drv = 1; tb_c2 = 2'b01; tb_d2 = line[16*(j-2-lat) +: 16];
      end else tb_drv = 0;
    end
    if (!hold) @(posedge clk);
  endtask

  // write line; b2b = request already pending while the bus reclaims
  task automatic do_write(input logic [17:0] addr, input logic [127:0] line,
                          input int lat, input bit b2b);
    int nrec;
    if (b2b) push(2'b00, '0, DREL, 1, 0, 0, 0, '0);
    else begin
      @(negedge clk); #2;
    end
    req_valid = 1; req_write = 1; req_addr = addr; req_wdata = line;
    for (int k = 0; k < WPL; k++) push(2'b11, addr, line[16*k +: 16], 0, 0, 0, 0, '0);
    push(REL, addr, DREL, 0, 0, 0, 0, '0);
    repeat (lat) push(REL, addr, DREL, 0, 0, 0, 0, '0);
    push(2'b01, addr, 16'h5A5A, 0, 0, 0, 0, '0);
    push(REL, addr, DREL, 0, 1, 0, 0, '0);
    nrec = WPL + 1 + lat + 1 + 1;
    if (b2b) repeat (2) @(posedge clk);
    else @(posedge clk);
    #1;
    req_valid = 0; req_write = 0; req_addr = ~addr; req_wdata = ~line;
    for (int j = 1; j < nrec; j++) begin
      @(posedge clk); #1;
      if (j == WPL + 1 + lat) begin
        tb_drv = 1; tb_c2 = 2'b01; tb_d2 = 16'h5A5A;
      end else tb_drv = 0;
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] l_rd1, l_wr, l_b;
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    tb_drv = 0; tb_c2 = '0; tb_d2 = '0;
    l_rd1 = mkline(16'h0011, 16'h0011);
    l_wr  = mkline(16'hA000, 16'h0001);
    l_b   = mkline(16'hB000, 16'h0001);

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_C2_released", c2, 2'b11);
    chk("rst_D2_released", d2, 16'hFFFF);
    chk("rst_A2", a2, 18'h0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_done", rsp_done, 1'b0);
    chk("rst_rdata", rsp_rdata, 128'h0);
    #1 rst_n = 1; exp_rdata = '0; chk_en = 1;
    #1 chk("post_rst_C2_nop", c2, 2'b00);

    // read, memory latency 100
    clr_mon();
    do_read(18'h12345, 100, WPL, l_rd1, 0);
    chk("rd_line", rsp_rdata, 128'h0088_0077_0066_0055_0044_0033_0022_0011);
    chk("rd_latency", 128'(done_cyc - cmd_cyc + 1), 128'd111);
    chk("rd_cmd_cycles", 128'(nrd), 128'd1);
    chk("rd_done_pulses", 128'(ndone), 128'd1);
    chk("rd_err", last_err, 1'b0);

    // write to top address
    clr_mon();
    do_write(18'h3FFFF, l_wr, 5, 0);
    chk("wr_data_cycles", 128'(nwr), 128'd8);
    chk("wr_latency", 128'(done_cyc - cmd_cyc + 1), 128'd16);
    chk("wr_done_pulses", 128'(ndone), 128'd1);

    // memory never responds
    clr_mon();
    do_read(18'h00ABC, 0, 0, '0, 0);
    chk("to_latency", 128'(done_cyc - cmd_cyc + 1), 128'(2 + TO + 1));
    chk("to_err", last_err, 1'b1);
    chk("to_rdata_kept", rsp_rdata, 128'h0088_0077_0066_0055_0044_0033_0022_0011);

    // next request after timeout, zero memory latency
    clr_mon();
    do_read(18'h00001, 0, WPL, mkline(16'h1000, 16'h0001), 0);
    chk("rd0_line", rsp_rdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    chk("rd0_latency", 128'(done_cyc - cmd_cyc + 1), 128'd11);

    // first response on the very cycle the timeout would fire
    clr_mon();
    do_read(18'h2AAAA, TO - 1, WPL, l_b, 0);
    chk("edge_err", last_err, 1'b0);
    chk("edge_line", rsp_rdata, 128'hB007_B006_B005_B004_B003_B002_B001_B000);

    // short burst: five words then RESPONSE drops
    clr_mon();
    do_read(18'h15555, 3, 5, mkline(16'hC000, 16'h0001), 0);
    chk("short_err", last_err, 1'b1);
    chk("short_rdata_kept", rsp_rdata, 128'hB007_B006_B005_B004_B003_B002_B001_B000);

    // reset during WDATA, right after word 3
    clr_mon();
    @(negedge clk); #2;
    req_valid = 1; req_write = 1; req_addr = 18'h00F0F; req_wdata = l_wr;
    for (int k = 0; k < 4; k++) push(2'b11, 18'h00F0F, l_wr[16*k +: 16], 0, 0, 0, 0, '0);
    @(posedge clk); #1;
    req_valid = 0;
    repeat (4) @(posedge clk);
    #2 chk_en = 0; rst_n = 0;
    #1;
    chk("mid_rst_C2", c2, 2'b11);
    chk("mid_rst_D2", d2, 16'hFFFF);
    chk("mid_rst_A2", a2, 18'h0);
    chk("mid_rst_ready", req_ready, 1'b0);
    @(negedge clk); #1;
    chk("mid_rst_no_done", rsp_done, 1'b0);
    chk("mid_rst_rdata", rsp_rdata, 128'h0);
    #1 rst_n = 1; exp_q.delete(); exp_rdata = '0; chk_en = 1;
    #1;
    chk("mid_rst_release_C2", c2, 2'b00);
    chk("mid_rst_release_ready", req_ready, 1'b1);
    chk("mid_rst_done_pulses", 128'(ndone), 128'd0);

    // back-to-back read then write with req_valid held high
    clr_mon();
    do_read(18'h00123, 2, WPL, l_rd1, 1);
    do_write(18'h00456, l_b, 1, 1);
    chk("b2b_idle_gap", 128'(gap), 128'd1);
    chk("b2b_done_pulses", 128'(ndone), 128'd2);

    repeat (4) @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
